// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   ADDR_W    : register address width
//   REG_ZERO  : address of the hard-wired zero register (never forwarded)
//   shadow_t  : per-stage record of an in-flight instruction
//   fwd_sel_w : width of a forward select able to encode 0..stages
package pipe_pkg;

  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] rd;
    logic              reg_we;
    logic              ld;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              use1;
    logic              use2;
  } shadow_t;

  function automatic int fwd_sel_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bus between the decode stage / pipeline control and the hazard unit.
//   master : drives ID instruction info, ex_redirect, ext_stall, clr_cnt;
//            receives stage enables, flush/bubble, forward selects, counters
//   slave  : the hazard unit side of the same signals
interface hazard_unit_if
  import pipe_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = fwd_sel_w(FWD_STAGES);

  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [ADDR_W-1:0] id_rd;
  logic              id_reg_we;
  logic              id_mem_read;
  logic              ex_redirect;
  logic              ext_stall;
  logic              clr_cnt;

  logic              if_we;
  logic              id_we;
  logic              ex_we;
  logic              mem_we;
  logic              if_flush;
  logic              bubble;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic              fwd_a_ld;
  logic              fwd_b_ld;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_we, id_mem_read, ex_redirect, ext_stall, clr_cnt,
    input  if_we, id_we, ex_we, mem_we, if_flush, bubble,
           fwd_a_sel, fwd_b_sel, fwd_a_ld, fwd_b_ld, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_we, id_mem_read, ex_redirect, ext_stall, clr_cnt,
    output if_we, id_we, ex_we, mem_we, if_flush, bubble,
           fwd_a_sel, fwd_b_sel, fwd_a_ld, fwd_b_ld, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk, rst : clock, asynchronous active-low reset (clears to 0)
//   inc      : count one event this cycle (ignored once all-ones)
//   clr      : synchronous clear, has priority over inc
//   cnt      : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding controller for a 5-stage pipeline.
// Tracks the instruction in EX (entry 0) and FWD_STAGES instructions
// downstream of it, produces forward selects, detects load-use hazards,
// arbitrates freeze / redirect / stall into stage enables and counts
// stall cycles and redirect events.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : hazard_unit_if slave (ID info in, enables/selects/counters out)
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  bus
);

  localparam int SEL_W = fwd_sel_w(FWD_STAGES);

  shadow_t          sh_q [0:FWD_STAGES];
  shadow_t          sh_d [0:FWD_STAGES];
  logic             luh;
  logic             if_we_w, down_we_w, flush_w, bubble_w;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             ld_a, ld_b;
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt_w, flush_cnt_w;
  logic             unused_fields;

  function automatic logic writes_reg(input shadow_t e);
    return e.v & e.reg_we & (e.rd != REG_ZERO);
  endfunction

  // ---- ID stage: load-use detection against loads not yet forwardable
  always_comb begin
    luh = 1'b0;
    if (bus.id_valid) begin
      for (int j = 0; j < LOAD_STAGE - 1; j++) begin
        if (writes_reg(sh_q[j]) && sh_q[j].ld &&
            ((bus.id_use_rs1 && (sh_q[j].rd == bus.id_rs1)) ||
             (bus.id_use_rs2 && (sh_q[j].rd == bus.id_rs2)))) begin
          luh = 1'b1;
        end
      end
    end
  end

  // Freeze beats redirect beats load-use; redirect discards the stalled
  // instruction anyway, so holding IF would only lose the fetch target.
  always_comb begin
    if_we_w   = 1'b1;
    down_we_w = 1'b1;
    flush_w   = 1'b0;
    bubble_w  = 1'b0;
    if (bus.ext_stall) begin
      if_we_w   = 1'b0;
      down_we_w = 1'b0;
    end else if (bus.ex_redirect) begin
      flush_w  = 1'b1;
      bubble_w = 1'b1;
    end else if (luh) begin
      if_we_w  = 1'b0;
      bubble_w = 1'b1;
    end
  end

  // ---- EX and downstream: forwarding, nearest producer wins
  always_comb begin
    sel_a = '0;
    ld_a  = 1'b0;
    sel_b = '0;
    ld_b  = 1'b0;
    if (sh_q[0].v) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (writes_reg(sh_q[k]) && sh_q[0].use1 && (sh_q[k].rd == sh_q[0].rs1)) begin
          sel_a = SEL_W'(k);
          ld_a  = sh_q[k].ld;
        end
        if (writes_reg(sh_q[k]) && sh_q[0].use2 && (sh_q[k].rd == sh_q[0].rs2)) begin
          sel_b = SEL_W'(k);
          ld_b  = sh_q[k].ld;
        end
      end
    end
  end

  // ---- shadow pipeline advance: ID -> EX -> downstream, frozen by ext_stall
  always_comb begin
    for (int k = 0; k <= FWD_STAGES; k++) begin
      sh_d[k] = sh_q[k];
    end
    if (!bus.ext_stall) begin
      sh_d[0].v      = bus.id_valid & ~bubble_w & ~bus.ex_redirect;
      sh_d[0].rd     = bus.id_rd;
      sh_d[0].reg_we = bus.id_reg_we;
      sh_d[0].ld     = bus.id_mem_read;
      sh_d[0].rs1    = bus.id_rs1;
      sh_d[0].rs2    = bus.id_rs2;
      sh_d[0].use1   = bus.id_use_rs1;
      sh_d[0].use2   = bus.id_use_rs2;
      for (int k = 1; k <= FWD_STAGES; k++) begin
        sh_d[k] = sh_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        sh_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        sh_q[k] <= sh_d[k];
      end
    end
  end

  // Source fields only matter while an entry sits in EX.
  always_comb begin
    unused_fields = 1'b0;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      unused_fields = unused_fields ^
                      (^{sh_q[k].rs1, sh_q[k].rs2, sh_q[k].use1, sh_q[k].use2});
    end
  end

  // ---- event counters
  assign stall_inc = luh & ~bus.ext_stall & ~bus.ex_redirect;
  assign flush_inc = bus.ex_redirect & ~bus.ext_stall;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (bus.clr_cnt),
    .cnt (stall_cnt_w)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .clr (bus.clr_cnt),
    .cnt (flush_cnt_w)
  );

  assign bus.if_we     = if_we_w;
  assign bus.id_we     = down_we_w;
  assign bus.ex_we     = down_we_w;
  assign bus.mem_we    = down_we_w;
  assign bus.if_flush  = flush_w;
  assign bus.bubble    = bubble_w;
  assign bus.fwd_a_sel = sel_a;
  assign bus.fwd_b_sel = sel_b;
  assign bus.fwd_a_ld  = ld_a;
  assign bus.fwd_b_ld  = ld_b;
  assign bus.stall_cnt = stall_cnt_w;
  assign bus.flush_cnt = flush_cnt_w;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (A: 2 fwd stages, load at 2, 16-bit
// counters; B: 3 fwd stages, load at 3, 4-bit counters) share one stimulus
// stream and are compared every cycle against an instruction-history model.
module tb_hazard_unit;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              id_valid, id_use_rs1, id_use_rs2, id_reg_we, id_mem_read;
  logic [ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic              ex_redirect, ext_stall, clr_cnt;

  hazard_unit_if #(.FWD_STAGES(2), .CNT_W(16)) ifa ();
  hazard_unit_if #(.FWD_STAGES(3), .CNT_W(4))  ifb ();

  hazard_unit #(.FWD_STAGES(2), .LOAD_STAGE(2), .CNT_W(16)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave));
  hazard_unit #(.FWD_STAGES(3), .LOAD_STAGE(3), .CNT_W(4)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave));

  assign ifa.id_valid = id_valid;       assign ifb.id_valid = id_valid;
  assign ifa.id_rs1 = id_rs1;           assign ifb.id_rs1 = id_rs1;
  assign ifa.id_rs2 = id_rs2;           assign ifb.id_rs2 = id_rs2;
  assign ifa.id_use_rs1 = id_use_rs1;   assign ifb.id_use_rs1 = id_use_rs1;
  assign ifa.id_use_rs2 = id_use_rs2;   assign ifb.id_use_rs2 = id_use_rs2;
  assign ifa.id_rd = id_rd;             assign ifb.id_rd = id_rd;
  assign ifa.id_reg_we = id_reg_we;     assign ifb.id_reg_we = id_reg_we;
  assign ifa.id_mem_read = id_mem_read; assign ifb.id_mem_read = id_mem_read;
  assign ifa.ex_redirect = ex_redirect; assign ifb.ex_redirect = ex_redirect;
  assign ifa.ext_stall = ext_stall;     assign ifb.ext_stall = ext_stall;
  assign ifa.clr_cnt = clr_cnt;         assign ifb.clr_cnt = clr_cnt;

  // observed values, {if_we,id_we,ex_we,mem_we,if_flush,bubble}
  logic [5:0]  ctl_g  [2];
  logic [1:0]  sela_g [2], selb_g [2];
  logic        lda_g  [2], ldb_g  [2];
  logic [15:0] stc_g  [2], flc_g  [2];
  assign ctl_g[0] = {ifa.if_we, ifa.id_we, ifa.ex_we, ifa.mem_we, ifa.if_flush, ifa.bubble};
  assign ctl_g[1] = {ifb.if_we, ifb.id_we, ifb.ex_we, ifb.mem_we, ifb.if_flush, ifb.bubble};
  assign sela_g[0] = ifa.fwd_a_sel; assign sela_g[1] = ifb.fwd_a_sel;
  assign selb_g[0] = ifa.fwd_b_sel; assign selb_g[1] = ifb.fwd_b_sel;
  assign lda_g[0] = ifa.fwd_a_ld;   assign lda_g[1] = ifb.fwd_a_ld;
  assign ldb_g[0] = ifa.fwd_b_ld;   assign ldb_g[1] = ifb.fwd_b_ld;
  assign stc_g[0] = ifa.stall_cnt;  assign stc_g[1] = {12'd0, ifb.stall_cnt};
  assign flc_g[0] = ifa.flush_cnt;  assign flc_g[1] = {12'd0, ifb.flush_cnt};

  // ---------------- reference model ----------------
  // hist[u][0] is the instruction now in EX, hist[u][d] is d instructions older.
  typedef struct {
    bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
  } ins_t;

  ins_t  hist [2][4];
  int    m_stall [2], m_flush [2];
  int    fs [2]   = '{2, 3};
  int    ls [2]   = '{2, 3};
  int    cmax [2] = '{65535, 15};
  string nm [2]   = '{"A", "B"};

  bit    e_luh [2];
  int    e_ctl [2], e_sela [2], e_selb [2];
  bit    e_lda [2], e_ldb [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit produces(input ins_t p, input int r);
    return p.v && p.wr && (p.rd != 0) && (p.rd == r);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int d = 0; d < 4; d++) hist[u][d] = '{default: 0};
      m_stall[u] = 0;
      m_flush[u] = 0;
    end
  endtask

  task automatic model_eval(input int u);
    ins_t ex;
    ex = hist[u][0];
    // a load younger than the forwardable age blocks a dependent in ID
    e_luh[u] = 1'b0;
    if (id_valid) begin
      for (int age = 0; age <= ls[u] - 2; age++) begin
        if (hist[u][age].ld &&
            ((id_use_rs1 && produces(hist[u][age], int'(id_rs1))) ||
             (id_use_rs2 && produces(hist[u][age], int'(id_rs2)))))
          e_luh[u] = 1'b1;
      end
    end
    // nearest older producer of each EX operand
    e_sela[u] = 0; e_lda[u] = 1'b0;
    e_selb[u] = 0; e_ldb[u] = 1'b0;
    if (ex.v && ex.u1) begin
      for (int d = 1; d <= fs[u]; d++) begin
        if (produces(hist[u][d], ex.rs1)) begin
          e_sela[u] = d; e_lda[u] = hist[u][d].ld; break;
        end
      end
    end
    if (ex.v && ex.u2) begin
      for (int d = 1; d <= fs[u]; d++) begin
        if (produces(hist[u][d], ex.rs2)) begin
          e_selb[u] = d; e_ldb[u] = hist[u][d].ld; break;
        end
      end
    end
    if (ext_stall)        e_ctl[u] = 6'b000000;
    else if (ex_redirect) e_ctl[u] = 6'b111111;
    else if (e_luh[u])    e_ctl[u] = 6'b011101;
    else                  e_ctl[u] = 6'b111100;
  endtask

  task automatic model_advance(input int u);
    if (!ext_stall) begin
      for (int d = fs[u]; d >= 1; d--) hist[u][d] = hist[u][d-1];
      hist[u][0].v   = id_valid && !e_ctl[u][0] && !ex_redirect;
      hist[u][0].rd  = int'(id_rd);
      hist[u][0].wr  = id_reg_we;
      hist[u][0].ld  = id_mem_read;
      hist[u][0].rs1 = int'(id_rs1);
      hist[u][0].rs2 = int'(id_rs2);
      hist[u][0].u1  = id_use_rs1;
      hist[u][0].u2  = id_use_rs2;
    end
    if (clr_cnt) begin
      m_stall[u] = 0;
      m_flush[u] = 0;
    end else begin
      if (e_luh[u] && !ext_stall && !ex_redirect && m_stall[u] < cmax[u]) m_stall[u]++;
      if (ex_redirect && !ext_stall && m_flush[u] < cmax[u]) m_flush[u]++;
    end
  endtask

  // ---------------- stepping ----------------
  task automatic settle();
    #1;
    for (int u = 0; u < 2; u++) begin
      model_eval(u);
      chk({nm[u], ".ctl"},   32'(ctl_g[u]),  32'(e_ctl[u]));
      chk({nm[u], ".sela"},  32'(sela_g[u]), 32'(e_sela[u]));
      chk({nm[u], ".lda"},   32'(lda_g[u]),  32'(e_lda[u]));
      chk({nm[u], ".selb"},  32'(selb_g[u]), 32'(e_selb[u]));
      chk({nm[u], ".ldb"},   32'(ldb_g[u]),  32'(e_ldb[u]));
      chk({nm[u], ".stall"}, 32'(stc_g[u]),  32'(m_stall[u]));
      chk({nm[u], ".flush"}, 32'(flc_g[u]),  32'(m_flush[u]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) for (int u = 0; u < 2; u++) model_advance(u);
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit we, input bit ld);
    id_valid = v;
    id_rs1 = ADDR_W'(rs1); id_use_rs1 = u1;
    id_rs2 = ADDR_W'(rs2); id_use_rs2 = u2;
    id_rd = ADDR_W'(rd); id_reg_we = we; id_mem_read = ld;
    ex_redirect = 1'b0; ext_stall = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // empty the pipe and zero the counters
  task automatic quiesce();
    nop(); clr_cnt = 1'b1; cycle();
    nop(); for (int i = 0; i < 4; i++) cycle();
  endtask

  // reset pulse inside the current cycle, checked while held and after release
  task automatic pulse_reset();
    rst = 1'b0;
    model_reset();
    settle();
    rst = 1'b1;
    settle();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    nop();
    model_reset();
    #1 rst = 1'b0;
    settle();
    chk("rst.ctl", 32'(ctl_g[0]), 32'h3C);
    chk("rst.cnt", 32'(stc_g[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    nop(); cycle(); cycle();

    // RAW, adjacent then one apart
    quiesce();
    set_id(1, 1, 1, 2, 1, 5, 1, 0); cycle();
    set_id(1, 5, 1, 0, 0, 6, 1, 0); cycle();
    nop(); settle();
    chk("raw1.sel", 32'(sela_g[0]), 32'd1);
    chk("raw1.ld",  32'(lda_g[0]),  32'd0);
    tick();
    set_id(1, 1, 1, 2, 1, 5, 1, 0); cycle();
    set_id(1, 1, 1, 2, 1, 9, 1, 0); cycle();
    set_id(1, 5, 1, 0, 0, 6, 1, 0); cycle();
    nop(); settle();
    chk("raw2.sel", 32'(sela_g[0]), 32'd2);
    tick();

    // load-use: A stalls 1 cycle, B stalls 2
    quiesce();
    set_id(1, 1, 1, 0, 0, 7, 1, 1); cycle();
    set_id(1, 7, 1, 2, 1, 8, 1, 0); settle();
    chk("lu.ifwe1", 32'(ifa.if_we),  32'd0);
    chk("lu.bub1",  32'(ifa.bubble), 32'd1);
    tick(); settle();
    chk("lu.ifwe2", 32'(ifa.if_we),  32'd1);
    chk("lu.Bifwe2", 32'(ifb.if_we), 32'd0);
    tick(); settle();
    chk("lu.sel",   32'(sela_g[0]), 32'd2);
    chk("lu.ld",    32'(lda_g[0]),  32'd1);
    chk("lu.stA",   32'(stc_g[0]),  32'd1);
    chk("lu.stB",   32'(stc_g[1]),  32'd2);
    tick();
    nop(); settle();
    chk("lu.Bsel",  32'(sela_g[1]), 32'd3);
    chk("lu.Bld",   32'(lda_g[1]),  32'd1);
    tick();

    // redirect coinciding with load-use
    quiesce();
    set_id(1, 1, 1, 0, 0, 7, 1, 1); cycle();
    set_id(1, 7, 1, 0, 0, 8, 1, 0); ex_redirect = 1'b1; settle();
    chk("rd.ctl", 32'(ctl_g[0]), 32'h3F);
    tick();
    nop(); settle();
    chk("rd.flush", 32'(flc_g[0]), 32'd1);
    chk("rd.stall", 32'(stc_g[0]), 32'd0);
    tick();

    // freeze during a pending forward, redirect held across it
    quiesce();
    set_id(1, 1, 1, 2, 1, 5, 1, 0); cycle();
    set_id(1, 5, 1, 0, 0, 6, 1, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      nop(); ext_stall = 1'b1; ex_redirect = 1'b1; settle();
      chk("frz.ctl", 32'(ctl_g[0]),  32'h00);
      chk("frz.sel", 32'(sela_g[0]), 32'd1);
      chk("frz.fl",  32'(flc_g[0]),  32'd0);
      tick();
    end
    nop(); ex_redirect = 1'b1; cycle();
    nop(); settle();
    chk("frz.fl1", 32'(flc_g[0]), 32'd1);
    tick();

    // x0 is neither forwarded nor a load-use source
    quiesce();
    set_id(1, 1, 1, 0, 0, 0, 1, 1); cycle();
    set_id(1, 0, 1, 0, 1, 6, 1, 0); settle();
    chk("x0.ifwe", 32'(ifa.if_we), 32'd1);
    tick();
    nop(); settle();
    chk("x0.sel", 32'(sela_g[0]), 32'd0);
    tick();

    // saturation on the 4-bit counters of B, then clear
    quiesce();
    for (int i = 0; i < 40; i++) begin
      set_id(1, 7, 1, 0, 0, 7, 1, 1); cycle();
    end
    nop(); settle();
    chk("sat.B", 32'(stc_g[1]), 32'd15);
    tick();
    nop(); clr_cnt = 1'b1; cycle();
    nop(); settle();
    chk("clr.B", 32'(stc_g[1]), 32'd0);
    tick();

    // reset in the middle of a stall
    quiesce();
    set_id(1, 1, 1, 0, 0, 7, 1, 1); cycle();
    set_id(1, 7, 1, 0, 0, 8, 1, 0); settle();
    rst = 1'b0;
    model_reset();
    #1;
    chk("mrst.ifwe", 32'(ifa.if_we),     32'd1);
    chk("mrst.cnt",  32'(stc_g[0]),      32'd0);
    rst = 1'b1;
    settle();
    tick();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = ADDR_W'($urandom_range(0, 3));
      id_rs2      = ADDR_W'($urandom_range(0, 3));
      id_use_rs1  = ($urandom_range(0, 3) != 0);
      id_use_rs2  = ($urandom_range(0, 1) != 0);
      id_rd       = ADDR_W'($urandom_range(0, 3));
      id_reg_we   = ($urandom_range(0, 3) != 0);
      id_mem_read = ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      ext_stall   = ($urandom_range(0, 7) == 0);
      clr_cnt     = ($urandom_range(0, 49) == 0);
      settle();
      if ($urandom_range(0, 149) == 0) pulse_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Successor to the fixed, externally driven stage enables and forward mux selects: this block generates them itself.
- Keeps a shadow pipeline of destination and usage info for in-flight instructions and detects load-use hazards over a configurable load latency.
- Arbitrates stall, flush and external freeze, and counts stall and flush events.

Parameters:
- ADDR_W, 5: register address width.
- FWD_STAGES, 2: number of downstream stages tracked and forwardable; stage 1 = EX/MEM, stage 2 = MEM/WB, and so on.
- LOAD_STAGE, 2: first stage index at which load data can be forwarded; legal range 1..FWD_STAGES.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  ADDR_W  ID source registers.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads that source.
- id_rd  in  ADDR_W  ID destination register.
- id_reg_we  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- ext_stall  in  1  freeze the whole pipeline (memory not ready).
- clr_cnt  in  1  synchronous clear of both counters.
- if_we  out  1  PC and IF/ID enable.
- id_we  out  1  ID/EX enable.
- ex_we  out  1  EX/MEM enable.
- mem_we  out  1  MEM/WB enable.
- if_flush  out  1  clear IF/ID on next edge.
- bubble  out  1  load zeros into ID/EX control fields.
- fwd_a_sel, fwd_b_sel  out  $clog2(FWD_STAGES+1)  0 = register file, k = stage k.
- fwd_a_ld, fwd_b_ld  out  1  selected stage is a load: use its memory data, not its ALU result.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  redirect events.

Behaviour:

Shadow pipeline:
- Entries S0..S_FWD_STAGES, where S0 is the instruction in EX.
- Each entry holds {v, rd, reg_we, ld, rs1, rs2, use1, use2}.
- On reset (rst=0, asynchronous) every v=0 and both counters are 0.
- Advance, when ext_stall=0:
  - S0 <= ID fields, with v = id_valid & ~bubble & ~ex_redirect.
  - Sk <= Sk-1 for all k >= 1.
- When ext_stall=1, every entry holds.

Forwarding (combinational from S0 and Sk, valid in the same cycle):
- For operand A, select the smallest k in 1..FWD_STAGES such that Sk.v & Sk.reg_we & Sk.rd!=0 & Sk.rd==S0.rs1 & S0.use1.
- fwd_a_sel = k and fwd_a_ld = Sk.ld; with no match, both are 0.
- Operand B is identical using rs2/use2.
- x0 is never forwarded.
- If S0.v=0, both selects are 0.

Load-use detection:
- luh=1 when id_valid and, for some j in 0..LOAD_STAGE-2, Sj.v & Sj.ld & Sj.reg_we & Sj.rd!=0 & Sj.rd matches an ID source that is in use.
- With LOAD_STAGE=1, luh is always 0.
- luh re-evaluates every cycle, so a stall lasts (LOAD_STAGE-1-j) cycles.

Enable priority (highest first):
- ext_stall=1: all four we=0, if_flush=0, bubble=0.
- ex_redirect=1: all we=1, if_flush=1, bubble=1. This overrides luh.
- luh=1: if_we=0, id_we=ex_we=mem_we=1, bubble=1, if_flush=0.
- Otherwise: all we=1, if_flush=0, bubble=0.
- After reset, with inputs idle: all we=1, flush and bubble 0, selects 0.

Counters:
- stall_cnt increments on cycles where luh=1, ext_stall=0 and ex_redirect=0.
- flush_cnt increments on cycles where ex_redirect=1 and ext_stall=0. ex_redirect held through a stall counts once, when the stall releases.
- Both counters saturate at all-ones.
- clr_cnt wins over increment.

Reset mid-operation:
- Asynchronous clear of shadow state and counters.
- Outputs settle to the idle values in the same cycle.

Decomposition:
- Shared package pipe_pkg: ADDR_W, the shadow entry struct, the fwd select width function, and the REG_ZERO constant.
- Sub-module sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- RAW without load: add x5 then add x6,x5 -> in the cycle the consumer is in EX, fwd_a_sel=1 and fwd_a_ld=0; with one independent instruction between them, fwd_a_sel=2.
- Load-use, LOAD_STAGE=2: lw x7 followed by sub using x7 -> exactly 1 cycle with if_we=0 and bubble=1, then fwd_a_sel=2, fwd_a_ld=1; stall_cnt=1.
- LOAD_STAGE=3, FWD_STAGES=3: lw then dependent -> 2 stall cycles, then fwd sel=3, ld=1; stall_cnt=2.
- ex_redirect together with luh -> if_flush=1, bubble=1, if_we=1, S0.v=0 next cycle; flush_cnt=1, stall_cnt unchanged.
- ext_stall for 3 cycles during a pending forward -> all we=0, selects stable, counters frozen; normal resume afterwards.
- rd=x0 writer followed by a reader of x0 -> sel=0 and no stall. Also: 0xFFFF stall events -> saturates at 0xFFFF; clr_cnt -> 0; rst low mid-stall -> if_we=1 and counters 0 immediately.
